handshake_arbiter: RTL and testbench
====================================

// Module: handshake_arbiter
// PURPOSE
//  Shares one downstream req/ack resource among NUM_REQ requesters with round-robin fairness.
//  Latches the winner's data, drives res_req_o/res_valid_o/res_data_o and waits for res_ack_i.
//  Times out to an error state when no ack arrives.
//  Sits in front of any handshake slave; its outputs are the signals the SVA suites check:
//  req/ack, valid/data, error_state, counter.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  DATA_W    8   payload width
//  TIMEOUT   10  max wait cycles for ack, 1..15 (4-bit counter)
//  ERR_HOLD  3   cycles error_state_o stays high after a timeout, >=1
// PORTS
//  clk            in   1                 clock, all logic on posedge
//  rst_n          in   1                 asynchronous active-low reset
//  req_i          in   NUM_REQ           per-requester request level
//  data_i         in   NUM_REQ*DATA_W    per-requester payload, slice k = requester k
//  grant_o        out  NUM_REQ           one-hot grant, held for the whole transaction
//  done_o         out  NUM_REQ           1-cycle pulse: requester k's transfer acked
//  res_req_o      out  1                 request to the shared resource
//  res_valid_o    out  1                 res_data_o valid; always equals res_req_o
//  res_data_o     out  DATA_W            latched payload of the granted requester
//  res_ack_i      in   1                 resource acknowledge
//  error_state_o  out  1                 timeout indication
//  counter_o      out  4                 wait cycles elapsed in current transaction
//  busy_o         out  1                 state != IDLE
// BEHAVIOUR
//  Reset:
//   - On rst_n low, asynchronously: state=IDLE, rr_ptr=0, and all outputs 0.
//   - Reset mid-transaction abandons it with no done_o pulse.
//  States: IDLE, WAIT_ACK, ERROR.
//  IDLE:
//   - req_i is sampled only in IDLE.
//   - If any req_i bit is set at cycle T, pick the first set bit k scanning rr_ptr, rr_ptr+1 .. (mod NUM_REQ).
//   - Latch data_i slice k and go to WAIT_ACK.
//   - At T+1: grant_o[k]=1, res_req_o=res_valid_o=1, res_data_o=latched data, counter_o=0.
//   - res_ack_i is ignored in IDLE.
//  WAIT_ACK:
//   - Each cycle without ack, counter_o increments by 1.
//   - grant_o, res_req_o and res_data_o hold stable; requester dropping req_i has no effect.
//   - Ack sampled high on the Nth WAIT cycle (N<=TIMEOUT): next cycle grant_o=0, res_req_o=0,
//     done_o[k]=1 for one cycle, counter_o=0, rr_ptr=(k+1)%NUM_REQ, state=IDLE.
//   - Ack and the timeout occur in the same cycle: ack wins.
//  Timeout:
//   - On the cycle counter_o==TIMEOUT-1 with no ack, next cycle state=ERROR.
//   - In that cycle res_req_o=0, grant_o=0, and no done_o.
//   - rr_ptr=(k+1)%NUM_REQ, so the failing requester loses priority.
//  ERROR:
//   - error_state_o=1 for exactly ERR_HOLD cycles, then IDLE with error_state_o=0.
//   - New requests are not accepted during ERROR; ack is ignored.
//  Throughput and latency:
//   - Minimum IDLE dwell is one cycle between transactions.
//   - Best-case request-to-grant latency is 1 cycle; transaction throughput is one per ack latency + 2 cycles.
//  Invariants:
//   - grant_o is one-hot-or-zero.
//   - res_req_o == |grant_o.
//   - done_o is nonzero only in the cycle after an ack.
//   - counter_o <= TIMEOUT-1.
// STRUCTURE
//  hs_arb_pkg:
//   - state_e {IDLE, WAIT_ACK, ERROR}.
//   - CNT_W=4.
//   - Function onehot_to_idx.
//  Sub-module rr_picker (combinational): inputs req vector and rr_ptr; outputs valid, index, one-hot.
//  Top level holds the FSM, data/index latch, wait counter and error-hold counter.
// TESTING
//  T1 single: req_i=0001, data=8'hA5, ack 3 cycles after res_req_o -> grant_o=0001 at T+1;
//     res_data_o=A5 stable; done_o[0] pulses once; counter_o reaches 2.
//  T2 fairness: req_i=1111 held, ack immediate each time -> grants in order 0,1,2,3,0;
//     one idle cycle between grants.
//  T3 timeout: req_i=0010, no ack -> res_req_o drops after TIMEOUT=10 cycles;
//     error_state_o high exactly 3 cycles; no done_o; next grant goes to 2 if requested.
//  T4 boundary: ack on same cycle counter_o==9 -> completes with done_o, no error_state_o.
//  T5 reset mid-WAIT: rst_n low for 1 cycle during WAIT_ACK -> all outputs 0 immediately;
//     next request from req_i=1000 grants requester 3 (rr_ptr back to 0, first set bit).
//  T6 stray ack: res_ack_i pulses in IDLE and ERROR -> no done_o; no state change.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// Shared types, widths and helpers for the round-robin handshake arbiter.
package hs_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERROR    = 2'd2
    } state_e;

    // Width of the wait-cycle counter; TIMEOUT must fit in it
    localparam int CNT_W   = 4;

    // Largest requester count the helpers are sized for
    localparam int MAX_REQ = 8;

    // Convert a one-hot (or zero) vector into the index of its set bit
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/handshake_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit starting at the pointer.
module rr_picker
    import hs_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_REQ-1:0] onehot_o
);

    logic [MAX_REQ-1:0] onehotExt;
    int                 pos;

    // Scan from the highest offset down so the lowest offset from ptr_i wins
    always_comb begin
        onehot_o  = '0;
        onehotExt = '0;
        pos       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = int'(ptr_i) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req_i[pos]) begin
                onehot_o      = '0;
                onehot_o[pos] = 1'b1;
            end
        end
        onehotExt[NUM_REQ-1:0] = onehot_o;
        valid_o = |req_i;
        idx_o   = IDX_W'(onehot_to_idx(onehotExt));
    end

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one req/ack resource, with ack timeout and error hold.
module handshake_arbiter
    import hs_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 10,
    parameter int ERR_HOLD = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic                        res_req_o,
    output logic                        res_valid_o,
    output logic [DATA_W-1:0]           res_data_o,
    input  logic                        res_ack_i,
    output logic                        error_state_o,
    output logic [CNT_W-1:0]            counter_o,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int ERR_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

    state_e               state_q;
    logic [IDX_W-1:0]     rrPtr_q;
    logic [IDX_W-1:0]     rrPtr_d;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [DATA_W-1:0]    data_q;
    logic [CNT_W-1:0]     count_q;
    logic [ERR_W-1:0]     errCnt_q;
    logic                 error_q;

    logic                 pickValid;
    logic [IDX_W-1:0]     pickIdx;
    logic [NUM_REQ-1:0]   pickOnehot;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i    (req_i),
        .ptr_i    (rrPtr_q),
        .valid_o  (pickValid),
        .idx_o    (pickIdx),
        .onehot_o (pickOnehot)
    );

    // Pointer value that demotes the current owner once its transaction ends
    always_comb begin
        rrPtr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    end

    // Main FSM: arbitration in IDLE, ack wait with timeout, then error hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rrPtr_q  <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            data_q   <= '0;
            count_q  <= '0;
            errCnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        state_q <= WAIT_ACK;
                        grant_q <= pickOnehot;
                        idx_q   <= pickIdx;
                        data_q  <= data_i[int'(pickIdx)*DATA_W +: DATA_W];
                        count_q <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (res_ack_i) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        done_q  <= grant_q;
                        count_q <= '0;
                        rrPtr_q <= rrPtr_d;
                    end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q  <= ERROR;
                        grant_q  <= '0;
                        count_q  <= '0;
                        rrPtr_q  <= rrPtr_d;
                        error_q  <= 1'b1;
                        errCnt_q <= '0;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ERROR: begin
                    if (errCnt_q == ERR_W'(ERR_HOLD - 1)) begin
                        state_q <= IDLE;
                        error_q <= 1'b0;
                    end else begin
                        errCnt_q <= errCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign done_o        = done_q;
    assign res_req_o     = |grant_q;
    assign res_valid_o   = |grant_q;
    assign res_data_o    = data_q;
    assign error_state_o = error_q;
    assign counter_o     = count_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_handshake_arbiter.sv
// Randomized self-checking bench for handshake_arbiter against a behavioural model.
module tb_handshake_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int TIMEOUT  = 10;
    localparam int ERR_HOLD = 3;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        grant_o;
    logic [NUM_REQ-1:0]        done_o;
    logic                      res_req_o;
    logic                      res_valid_o;
    logic [DATA_W-1:0]         res_data_o;
    logic                      res_ack_i;
    logic                      error_state_o;
    logic [3:0]                counter_o;
    logic                      busy_o;

    handshake_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .ERR_HOLD (ERR_HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .data_i        (data_i),
        .grant_o       (grant_o),
        .done_o        (done_o),
        .res_req_o     (res_req_o),
        .res_valid_o   (res_valid_o),
        .res_data_o    (res_data_o),
        .res_ack_i     (res_ack_i),
        .error_state_o (error_state_o),
        .counter_o     (counter_o),
        .busy_o        (busy_o)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectorCount = 0;
    int miscompares = 0;

    // Behavioural model state: who owns the resource, how long it waited,
    // how much error hold remains, and whose turn starts the next scan.
    int                owner;
    int                waitCycles;
    int                errorLeft;
    int                turn;
    int                expDone;
    logic [DATA_W-1:0] latched;
    logic [DATA_W-1:0] dataArr [NUM_REQ];
    int                grantLog [$];

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        owner      = -1;
        waitCycles = 0;
        errorLeft  = 0;
        turn       = 0;
        expDone    = 0;
        latched    = '0;
    endtask

    // Advance the model by one clock using the inputs presented this cycle
    task automatic modelStep();
        bit found;
        expDone = 0;
        if (errorLeft > 0) begin
            errorLeft--;
        end else if (owner >= 0) begin
            if (res_ack_i) begin
                expDone    = 1 << owner;
                turn       = (owner + 1) % NUM_REQ;
                owner      = -1;
                waitCycles = 0;
            end else if (waitCycles == TIMEOUT - 1) begin
                turn       = (owner + 1) % NUM_REQ;
                owner      = -1;
                waitCycles = 0;
                errorLeft  = ERR_HOLD;
            end else begin
                waitCycles++;
            end
        end else begin
            found = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                int k;
                k = (turn + i) % NUM_REQ;
                if (!found && req_i[k]) begin
                    found      = 1'b1;
                    owner      = k;
                    latched    = dataArr[k];
                    waitCycles = 0;
                    grantLog.push_back(k);
                end
            end
        end
    endtask

    // Check every output against the model
    task automatic checkAll();
        int expGrant;
        expGrant = (owner >= 0) ? (1 << owner) : 0;
        checkOutput("grant", 32'(grant_o), 32'(expGrant));
        checkOutput("done", 32'(done_o), 32'(expDone));
        checkOutput("resReq", 32'(res_req_o), 32'(owner >= 0));
        checkOutput("resValid", 32'(res_valid_o), 32'(owner >= 0));
        checkOutput("counter", 32'(counter_o), 32'(waitCycles));
        checkOutput("errorState", 32'(error_state_o), 32'(errorLeft > 0));
        checkOutput("busy", 32'(busy_o), 32'((owner >= 0) || (errorLeft > 0)));
        if (owner >= 0) begin
            checkOutput("resData", 32'(res_data_o), 32'(latched));
        end
    endtask

    task automatic packData();
        for (int k = 0; k < NUM_REQ; k++) begin
            data_i[k*DATA_W +: DATA_W] = dataArr[k];
        end
    endtask

    task automatic randomizeData();
        for (int k = 0; k < NUM_REQ; k++) begin
            dataArr[k] = DATA_W'($urandom);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check outputs after the edge
    task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic ack);
        req_i     = req;
        res_ack_i = ack;
        packData();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    // Pulse reset away from the clock edge and check outputs clear at once
    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("resetGrant", 32'(grant_o), 32'd0);
        checkOutput("resetReq", 32'(res_req_o), 32'd0);
        checkOutput("resetCounter", 32'(counter_o), 32'd0);
        checkOutput("resetBusy", 32'(busy_o), 32'd0);
        checkOutput("resetError", 32'(error_state_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkAll();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_i     = '0;
        res_ack_i = 1'b0;
        randomizeData();
        packData();
        modelReset();
        #2;
        checkAll();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: single requester, ack on the third wait cycle
        $display("[TB] single transfer");
        dataArr[0] = 8'hA5;
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t1Grant", 32'(grant_o), 32'h1);
        checkOutput("t1Data", 32'(res_data_o), 32'hA5);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t1Counter", 32'(counter_o), 32'd2);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t1Done", 32'(done_o), 32'h1);
        applyStimulus(4'b0000, 1'b0);

        // T2: all requesting, immediate ack, grants must rotate 1,2,3,0,1
        $display("[TB] fairness");
        grantLog.delete();
        for (int n = 0; n < 5; n++) begin
            randomizeData();
            applyStimulus(4'b1111, 1'b0);
            applyStimulus(4'b1111, 1'b1);
        end
        for (int n = 0; n < 5; n++) begin
            checkOutput("t2Order", 32'(grantLog[n]), 32'((n + 1) % NUM_REQ));
        end

        // T3: timeout with no ack, then requester 2 gets the next grant
        $display("[TB] timeout");
        applyStimulus(4'b0010, 1'b0);
        for (int n = 0; n < TIMEOUT + ERR_HOLD; n++) begin
            applyStimulus(4'b0110, 1'b1 & (n >= TIMEOUT));
        end
        applyStimulus(4'b0110, 1'b0);
        checkOutput("t3NextGrant", 32'(grant_o), 32'h4);
        while (owner >= 0) begin
            applyStimulus(4'b0000, waitCycles == 2);
        end
        applyStimulus(4'b0000, 1'b0);

        // T4: ack lands on the last permitted wait cycle
        $display("[TB] ack at timeout boundary");
        applyStimulus(4'b1000, 1'b0);
        for (int n = 0; n < TIMEOUT; n++) begin
            applyStimulus(4'b0000, waitCycles == TIMEOUT - 1);
        end
        checkOutput("t4Done", 32'(done_o), 32'h8);
        checkOutput("t4NoError", 32'(error_state_o), 32'd0);

        // T5: reset during a wait, then requester 3 alone
        $display("[TB] reset mid-transaction");
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        pulseReset();
        applyStimulus(4'b1000, 1'b0);
        checkOutput("t5Grant", 32'(grant_o), 32'h8);
        applyStimulus(4'b0000, 1'b1);

        // T6: stray acks while idle and in error
        $display("[TB] stray ack");
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b0);
        for (int n = 0; n < TIMEOUT; n++) begin
            applyStimulus(4'b0000, 1'b0);
        end
        for (int n = 0; n < ERR_HOLD + 2; n++) begin
            applyStimulus(4'b0000, 1'b1);
        end

        // Random traffic with occasional reset
        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            randomizeData();
            if ($urandom_range(0, 299) == 0) begin
                pulseReset();
            end else begin
                applyStimulus(NUM_REQ'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
